// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
// Purpose : Shared definitions for the ID/EX pipeline stage and its hazard
//           unit. Holds the ALU operation encodings, the datapath and
//           register-index widths, and the packed control bundle that
//           travels from ID to EX.
// Contents: alu_op_t  - ALU operation encodings
//           DW, RW    - datapath / register-index widths
//           ctrl_t    - control bundle, BUBBLE = all-zero (no side effect)
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

  localparam int DW = 32;
  localparam int RW = 5;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011
  } alu_op_t;

  typedef struct packed {
    logic [3:0] ALUCtrl;
    logic       Branch;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       ALUSrc;
  } ctrl_t;

  // A bubble clears every control bit, so nothing downstream writes state.
  localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
// Purpose : Combinational load-use detection between the instruction in EX
//           and the instruction in ID. Kept separate so a forwarding unit
//           can reuse the same comparison logic.
// Ports   : exValid, exMemRead, exRt   - registered EX state
//           idValid, idRs, idRt        - ID instruction operands
//           idALUSrc, idMemWrite,
//           idBranch                   - decide whether ID reads rt
//           flush                      - branch squash (suppresses stall)
//           loadUse                    - raw load-use condition
//           hazardStall                - freeze PC and IF/ID this cycle
// ---------------------------------------------------------------------------
module hazard_unit
  import id_ex_stage_pkg::*;
#(
  parameter int RW = id_ex_stage_pkg::RW
) (
  input  logic          exValid,
  input  logic          exMemRead,
  input  logic [RW-1:0] exRt,
  input  logic          idValid,
  input  logic [RW-1:0] idRs,
  input  logic [RW-1:0] idRt,
  input  logic          idALUSrc,
  input  logic          idMemWrite,
  input  logic          idBranch,
  input  logic          flush,
  output logic          loadUse,
  output logic          hazardStall
);

  logic idUsesRt;

  // rt is a source for R-type ops (no immediate), stores and branches.
  assign idUsesRt = ~idALUSrc | idMemWrite | idBranch;

  // $0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign loadUse = exValid & exMemRead & (exRt != '0) & idValid &
                   ((exRt == idRs) | (idUsesRt & (exRt == idRt)));

  // A flushed ID instruction is discarded anyway, so there is nothing to hold.
  assign hazardStall = loadUse & ~flush;

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// Purpose : ID/EX pipeline register of the 5-stage MIPS core. Registers the
//           decoded operands, extended immediate and control bits for EX,
//           inserts one bubble per load-use hazard, honours branch flush and
//           data-memory stall, and counts load-use bubbles (saturating).
// Ports   : clk, rst (async, active-high)
//           id_*        - decoded instruction from ID
//           flush       - squash ID instruction (taken branch)
//           mem_stall   - global freeze from data memory
//           ex_*        - registered copies presented to EX
//           hazard_stall- combinational, deasserts PC / IF/ID write
//           bubble_cnt  - saturating load-use bubble count
// ---------------------------------------------------------------------------
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW = id_ex_stage_pkg::DW,
  parameter int RW = id_ex_stage_pkg::RW,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [DW-1:0] id_pc,
  input  logic [DW-1:0] id_rd1,
  input  logic [DW-1:0] id_rd2,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [3:0]    id_ALUCtrl,
  input  logic          id_Branch,
  input  logic          id_MemRead,
  input  logic          id_MemWrite,
  input  logic          id_RegWrite,
  input  logic          id_MemtoReg,
  input  logic          id_RegDst,
  input  logic          id_ALUSrc,
  input  logic          flush,
  input  logic          mem_stall,
  output logic          ex_valid,
  output logic [DW-1:0] ex_pc,
  output logic [DW-1:0] ex_rd1,
  output logic [DW-1:0] ex_rd2,
  output logic [DW-1:0] ex_imm,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_rd,
  output logic [3:0]    ex_ALUCtrl,
  output logic          ex_Branch,
  output logic          ex_MemRead,
  output logic          ex_MemWrite,
  output logic          ex_RegWrite,
  output logic          ex_MemtoReg,
  output logic          ex_RegDst,
  output logic          ex_ALUSrc,
  output logic          hazard_stall,
  output logic [CW-1:0] bubble_cnt
);

  ctrl_t         idCtrl;
  ctrl_t         exCtrlReg;
  logic          exValidReg;
  logic [DW-1:0] exPcReg;
  logic [DW-1:0] exRd1Reg;
  logic [DW-1:0] exRd2Reg;
  logic [DW-1:0] exImmReg;
  logic [RW-1:0] exRsReg;
  logic [RW-1:0] exRtReg;
  logic [RW-1:0] exRdReg;
  logic [CW-1:0] bubbleCntReg;
  logic          loadUse;

  assign idCtrl = '{ALUCtrl:  id_ALUCtrl,
                    Branch:   id_Branch,
                    MemRead:  id_MemRead,
                    MemWrite: id_MemWrite,
                    RegWrite: id_RegWrite,
                    MemtoReg: id_MemtoReg,
                    RegDst:   id_RegDst,
                    ALUSrc:   id_ALUSrc};

  hazard_unit #(.RW(RW)) uHazard (
    .exValid     (exValidReg),
    .exMemRead   (exCtrlReg.MemRead),
    .exRt        (exRtReg),
    .idValid     (id_valid),
    .idRs        (id_rs),
    .idRt        (id_rt),
    .idALUSrc    (id_ALUSrc),
    .idMemWrite  (id_MemWrite),
    .idBranch    (id_Branch),
    .flush       (flush),
    .loadUse     (loadUse),
    .hazardStall (hazard_stall)
  );

  // Priority: memory stall freezes everything (including a pending load-use,
  // which simply re-evaluates once the stall drops), then flush, then
  // load-use, then normal capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exValidReg   <= 1'b0;
      exCtrlReg    <= BUBBLE;
      exPcReg      <= '0;
      exRd1Reg     <= '0;
      exRd2Reg     <= '0;
      exImmReg     <= '0;
      exRsReg      <= '0;
      exRtReg      <= '0;
      exRdReg      <= '0;
      bubbleCntReg <= '0;
    end else if (!mem_stall) begin
      if (flush || loadUse) begin
        exValidReg <= 1'b0;
        exCtrlReg  <= BUBBLE;
        exPcReg    <= '0;
        exRd1Reg   <= '0;
        exRd2Reg   <= '0;
        exImmReg   <= '0;
        exRsReg    <= '0;
        exRtReg    <= '0;
        exRdReg    <= '0;
        // Only genuine load-use bubbles are counted; flush bubbles are not.
        if (!flush && (bubbleCntReg != '1)) begin
          bubbleCntReg <= bubbleCntReg + CW'(1);
        end
      end else begin
        exValidReg <= id_valid;
        exCtrlReg  <= idCtrl;
        exPcReg    <= id_pc;
        exRd1Reg   <= id_rd1;
        exRd2Reg   <= id_rd2;
        exImmReg   <= id_imm;
        exRsReg    <= id_rs;
        exRtReg    <= id_rt;
        exRdReg    <= id_rd;
      end
    end
  end

  assign ex_valid    = exValidReg;
  assign ex_pc       = exPcReg;
  assign ex_rd1      = exRd1Reg;
  assign ex_rd2      = exRd2Reg;
  assign ex_imm      = exImmReg;
  assign ex_rs       = exRsReg;
  assign ex_rt       = exRtReg;
  assign ex_rd       = exRdReg;
  assign ex_ALUCtrl  = exCtrlReg.ALUCtrl;
  assign ex_Branch   = exCtrlReg.Branch;
  assign ex_MemRead  = exCtrlReg.MemRead;
  assign ex_MemWrite = exCtrlReg.MemWrite;
  assign ex_RegWrite = exCtrlReg.RegWrite;
  assign ex_MemtoReg = exCtrlReg.MemtoReg;
  assign ex_RegDst   = exCtrlReg.RegDst;
  assign ex_ALUSrc   = exCtrlReg.ALUSrc;
  assign bubble_cnt  = bubbleCntReg;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Purpose : Self-checking bench for id_ex_stage (CW=2 so saturation is
//           reachable). Expected EX contents are queued when an instruction
//           is driven and compared one edge later.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = '0, id_rd1 = '0, id_rd2 = '0, id_imm = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic [3:0]  id_ALUCtrl = '0;
  logic        id_Branch = 0, id_MemRead = 0, id_MemWrite = 0, id_RegWrite = 0;
  logic        id_MemtoReg = 0, id_RegDst = 0, id_ALUSrc = 0;
  logic        flush = 1'b0, mem_stall = 1'b0;

  logic        ex_valid;
  logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [3:0]  ex_ALUCtrl;
  logic        ex_Branch, ex_MemRead, ex_MemWrite, ex_RegWrite;
  logic        ex_MemtoReg, ex_RegDst, ex_ALUSrc;
  logic        hazard_stall;
  logic [1:0]  bubble_cnt;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rt;
    logic        memRead;
    logic        memWrite;
    logic        regWrite;
    logic [1:0]  cnt;
  } exp_t;

  exp_t sbQ[$];

  always #5 clk = ~clk;

  id_ex_stage #(.DW(32), .RW(5), .CW(2)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_ALUCtrl(id_ALUCtrl), .id_Branch(id_Branch), .id_MemRead(id_MemRead),
    .id_MemWrite(id_MemWrite), .id_RegWrite(id_RegWrite),
    .id_MemtoReg(id_MemtoReg), .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc),
    .flush(flush), .mem_stall(mem_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_ALUCtrl(ex_ALUCtrl), .ex_Branch(ex_Branch), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_RegWrite(ex_RegWrite),
    .ex_MemtoReg(ex_MemtoReg), .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc),
    .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                              input logic [4:0] rt, input logic mr, input logic mw,
                              input logic rw, input logic [1:0] cnt);
    exp_t e;
    e.valid = v; e.pc = pc; e.imm = imm; e.rt = rt;
    e.memRead = mr; e.memWrite = mw; e.regWrite = rw; e.cnt = cnt;
    return e;
  endfunction

  function automatic exp_t bubble(input logic [1:0] cnt);
    return mk(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, cnt);
  endfunction

  task automatic setId(input logic v, input logic [31:0] pc, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [31:0] imm, input logic asrc,
                       input logic mr, input logic mw, input logic rw);
    id_valid = v; id_pc = pc; id_rs = rs; id_rt = rt; id_rd = rt + 5'd1;
    id_imm = imm; id_rd1 = pc ^ 32'hA5A5_0000; id_rd2 = pc ^ 32'h0000_5A5A;
    id_ALUCtrl = 4'b0000; id_Branch = 1'b0; id_RegDst = ~asrc;
    id_ALUSrc = asrc; id_MemRead = mr; id_MemWrite = mw; id_RegWrite = rw;
    id_MemtoReg = mr;
  endtask

  task automatic idAdd(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt);
    setId(1'b1, pc, rs, rt, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic idLw(input logic [31:0] pc, input logic [4:0] rt);
    setId(1'b1, pc, 5'd1, rt, 32'h4, 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  // Drive cycle: inputs already set at negedge; check stall, queue result,
  // then compare one edge later.
  task automatic step(input string tag, input logic hzExp, input exp_t e);
    exp_t got;
    #1;
    chk({tag, ".hazard_stall"}, {31'b0, hazard_stall}, {31'b0, hzExp});
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    if (sbQ.size() == 0) begin
      chk({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      got = sbQ.pop_front();
      chk({tag, ".ex_valid"},    {31'b0, ex_valid},    {31'b0, got.valid});
      chk({tag, ".ex_pc"},       ex_pc,                got.pc);
      chk({tag, ".ex_imm"},      ex_imm,               got.imm);
      chk({tag, ".ex_rt"},       {27'b0, ex_rt},       {27'b0, got.rt});
      chk({tag, ".ex_MemRead"},  {31'b0, ex_MemRead},  {31'b0, got.memRead});
      chk({tag, ".ex_MemWrite"}, {31'b0, ex_MemWrite}, {31'b0, got.memWrite});
      chk({tag, ".ex_RegWrite"}, {31'b0, ex_RegWrite}, {31'b0, got.regWrite});
      chk({tag, ".bubble_cnt"},  {30'b0, bubble_cnt},  {30'b0, got.cnt});
    end
    $display("[TB] %s: ex_valid=%0b ex_pc=%h bubble_cnt=%0d", tag, ex_valid, ex_pc, bubble_cnt);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #20000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin : stim
    logic [1:0] cntExp;

    @(negedge clk);
    chk("reset.ex_valid",   {31'b0, ex_valid},   32'd0);
    chk("reset.bubble_cnt", {30'b0, bubble_cnt}, 32'd0);
    chk("reset.ex_pc",      ex_pc,               32'd0);
    rst = 1'b0;

    // Pass-through
    setId(1'b1, 32'h0000_0404, 5'd1, 5'd2, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("pass", 1'b0, mk(1, 32'h404, 32'hFFFF_FFF0, 5'd2, 0, 0, 1, 2'd0));
    chk("pass.ex_rd1", ex_rd1, 32'h0000_0404 ^ 32'hA5A5_0000);

    // Load-use: lw rt=8 then add rs=8
    idLw(32'h408, 5'd8);
    step("lw8", 1'b0, mk(1, 32'h408, 32'h4, 5'd8, 1, 0, 1, 2'd0));
    idAdd(32'h40C, 5'd8, 5'd3);
    step("lu_bubble", 1'b1, bubble(2'd1));
    step("lu_resume", 1'b0, mk(1, 32'h40C, 32'h0, 5'd3, 0, 0, 1, 2'd1));

    // $0 never hazards
    idLw(32'h410, 5'd0);
    step("lw0", 1'b0, mk(1, 32'h410, 32'h4, 5'd0, 1, 0, 1, 2'd1));
    idAdd(32'h414, 5'd0, 5'd0);
    step("add_r0", 1'b0, mk(1, 32'h414, 32'h0, 5'd0, 0, 0, 1, 2'd1));

    // addi uses rt as destination: no hazard
    idLw(32'h418, 5'd9);
    step("lw9a", 1'b0, mk(1, 32'h418, 32'h4, 5'd9, 1, 0, 1, 2'd1));
    setId(1'b1, 32'h41C, 5'd1, 5'd9, 32'h10, 1'b1, 1'b0, 1'b0, 1'b1);
    step("addi_rt9", 1'b0, mk(1, 32'h41C, 32'h10, 5'd9, 0, 0, 1, 2'd1));

    // sw reads rt: hazard
    idLw(32'h420, 5'd9);
    step("lw9b", 1'b0, mk(1, 32'h420, 32'h4, 5'd9, 1, 0, 1, 2'd1));
    setId(1'b1, 32'h424, 5'd1, 5'd9, 32'h8, 1'b1, 1'b0, 1'b1, 1'b0);
    step("sw_bubble", 1'b1, bubble(2'd2));
    step("sw_resume", 1'b0, mk(1, 32'h424, 32'h8, 5'd9, 0, 1, 0, 2'd2));

    // flush beats load-use, count unchanged
    idLw(32'h428, 5'd10);
    step("lw10", 1'b0, mk(1, 32'h428, 32'h4, 5'd10, 1, 0, 1, 2'd2));
    idAdd(32'h42C, 5'd10, 5'd4);
    flush = 1'b1;
    step("flush_lu", 1'b0, bubble(2'd2));
    flush = 1'b0;

    // mem_stall freezes EX for 3 cycles
    idAdd(32'h500, 5'd1, 5'd4);
    step("pre_stall", 1'b0, mk(1, 32'h500, 32'h0, 5'd4, 0, 0, 1, 2'd2));
    idLw(32'h600, 5'd6);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step($sformatf("stall%0d", i), 1'b0, mk(1, 32'h500, 32'h0, 5'd4, 0, 0, 1, 2'd2));
    end
    mem_stall = 1'b0;
    step("post_stall", 1'b0, mk(1, 32'h600, 32'h4, 5'd6, 1, 0, 1, 2'd2));

    // Saturation: 5 more load-use events on a 2-bit counter
    cntExp = 2'd2;
    for (int i = 0; i < 5; i++) begin
      idLw(32'h700 + 32'(i * 8), 5'd11);
      step($sformatf("sat_lw%0d", i), 1'b0,
           mk(1, 32'h700 + 32'(i * 8), 32'h4, 5'd11, 1, 0, 1, cntExp));
      idAdd(32'h704 + 32'(i * 8), 5'd11, 5'd2);
      cntExp = (cntExp == 2'd3) ? 2'd3 : cntExp + 2'd1;
      step($sformatf("sat_lu%0d", i), 1'b1, bubble(cntExp));
    end

    // Asynchronous reset mid-cycle with a live instruction in EX
    idAdd(32'h800, 5'd1, 5'd2);
    step("pre_reset", 1'b0, mk(1, 32'h800, 32'h0, 5'd2, 0, 0, 1, 2'd3));
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst.ex_valid",    {31'b0, ex_valid},    32'd0);
    chk("async_rst.ex_RegWrite", {31'b0, ex_RegWrite}, 32'd0);
    chk("async_rst.ex_pc",       ex_pc,                32'd0);
    chk("async_rst.bubble_cnt",  {30'b0, bubble_cnt},  32'd0);
    $display("[TB] async_rst: ex_valid=%0b bubble_cnt=%0d", ex_valid, bubble_cnt);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 5-stage MIPS core, directly downstream of the decode-stage immediate extender.
- Registers decoded operands, the 32-bit extended immediate and control bits for EX.
- Detects load-use hazards, inserting one bubble and freezing PC and IF/ID for that cycle.
- Applies branch flush and external memory stall; counts inserted bubbles for performance debug.

Parameters:
- DW, 32, datapath width (PC, register data, immediate).
- RW, 5, register index width.
- CW, 16, bubble counter width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  DW  PC+4 of ID instruction.
- id_rd1, id_rd2  in  DW  register file read data.
- id_imm  in  DW  extended immediate from the extender.
- id_rs, id_rt, id_rd  in  RW  register indices.
- id_ALUCtrl  in  4  ALU operation.
- id_Branch, id_MemRead, id_MemWrite, id_RegWrite, id_MemtoReg, id_RegDst, id_ALUSrc  in  1 each  control bits.
- flush  in  1  squash ID instruction (taken branch resolved).
- mem_stall  in  1  global freeze from data memory.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc, ex_rd1, ex_rd2, ex_imm  out  DW  registered copies.
- ex_rs, ex_rt, ex_rd  out  RW  registered copies.
- ex_ALUCtrl  out  4; ex_Branch, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg, ex_RegDst, ex_ALUSrc  out  1 each.
- hazard_stall  out  1  combinational; deasserts PC write and IF/ID write.
- bubble_cnt  out  CW  saturating count of load-use bubbles.

Behaviour:
- Reset (async, immediate): every ex_* output 0, ex_valid 0, bubble_cnt 0. Release is clean at the next clk edge.
- rt-use rule: id_uses_rt = ~id_ALUSrc | id_MemWrite | id_Branch.
- Load-use: lu = ex_valid & ex_MemRead & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
- hazard_stall = lu & ~flush. Purely combinational from registered EX state and ID inputs, so it is valid in the same cycle.
- Per rising edge, the first matching action applies:
  1. mem_stall=1: hold every ex_* register and bubble_cnt unchanged.
  2. flush=1: insert bubble.
  3. lu=1: insert bubble; bubble_cnt += 1, saturating at all-ones.
  4. Otherwise: capture all id_* into ex_*; ex_valid <= id_valid.
- Bubble: ex_valid, ex_Branch, ex_MemRead, ex_MemWrite and ex_RegWrite all 0; every other ex_* field 0. No architectural side effect downstream.
- Latency: 1 cycle ID to EX.
- Load-use resolution: exactly one bubble per load-use. On the next cycle the load has left EX, lu deasserts and the held ID instruction is captured.
- id_valid=0 with no flush or lu: captured as ex_valid=0. Control bits are still captured; downstream qualifies them with ex_valid.
- Register $0 never triggers a hazard.
- flush together with lu: flush wins, hazard_stall=0, bubble_cnt is not incremented.
- mem_stall together with lu: hazard_stall is still asserted, but the EX register holds. The hazard re-evaluates after mem_stall drops.
- bubble_cnt holds at saturation; only rst clears it.

Decomposition:
- Shared package holds:
  - ALUCtrl encodings: ADD 4'b0000, AND 4'b0010, OR 4'b0011.
  - Width constants DW/RW.
  - A control-bundle struct {ALUCtrl, Branch, MemRead, MemWrite, RegWrite, MemtoReg, RegDst, ALUSrc} with a BUBBLE constant of all zeros.
- One sub-module: hazard_unit, the combinational lu/hazard_stall logic, reusable by a future forwarding unit.
- The pipeline register stays in id_ex_stage.

Test Plan:
- Reset: assert rst mid-cycle with ex_valid=1, ex_RegWrite=1 -> all ex_* and bubble_cnt read 0 before the next edge.
- Pass-through: id_valid=1, id_pc=0x00000404, id_imm=0xFFFFFFF0, id_ALUCtrl=0000, RegWrite=1 -> next cycle ex_pc=0x404, ex_imm=0xFFFFFFF0, ex_valid=1, hazard_stall=0.
- Load-use: EX holds lw with rt=8; ID holds add with rs=8 -> hazard_stall=1 that cycle, next ex_valid=0 and bubble_cnt=1. Following cycle: add captured, hazard_stall=0.
- No false hazard:
  - lw with rt=0 followed by add rs=0 -> hazard_stall=0.
  - lw rt=9 then addi with rt=9 (ALUSrc=1, not store) -> hazard_stall=0.
  - lw rt=9 then sw with rt=9 -> hazard_stall=1.
- Priority:
  - flush=1 coincident with a load-use -> bubble inserted, hazard_stall=0, bubble_cnt unchanged.
  - mem_stall=1 for 3 cycles -> ex_* frozen throughout, then resumes.
- Saturation: CW=2, force 5 load-use events -> bubble_cnt reaches 3 and stays 3.
